// File: rtl/bram_loader.sv
// Packs a stream of 32-bit beats into 96-bit BRAM words (beat 0 in the low bits) and
// writes them to consecutive addresses starting at a commanded base, wrapping at the top.
module bram_loader #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [31:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [1:0]            LAST_BEAT = 2'd2;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic [ADDR_WIDTH:0]   word_cnt_inc;
    logic [1:0]            beat_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  beat_fire;

    assign beat_fire    = (state == LOAD) && s_valid;
    assign word_cnt_inc = word_cnt_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : LOAD;
            LOAD:    if (beat_fire && (beat_q == LAST_BEAT)) state_nxt = WRITE;
            WRITE:   state_nxt = (word_cnt_inc == len_q) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath is reset too, so an interrupted command leaves no partial word behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            beat_q     <= '0;
            word_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q     <= cmd_base;
                        len_q      <= cmd_len;
                        word_cnt_q <= '0;
                        beat_q     <= '0;
                    end
                end
                LOAD: begin
                    if (beat_fire) begin
                        case (beat_q)
                            2'd0:    word_q[31:0]  <= s_data;
                            2'd1:    word_q[63:32] <= s_data;
                            default: word_q[95:64] <= s_data;
                        endcase
                        beat_q <= (beat_q == LAST_BEAT) ? 2'd0 : beat_q + 2'd1;
                    end
                end
                WRITE: begin
                    addr_q     <= addr_q + ADDR_ONE;
                    word_cnt_q <= word_cnt_inc;
                    beat_q     <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Every output is a register or a decode of the state register.
    assign cmd_ready = (state == IDLE);
    assign s_ready   = (state == LOAD);
    assign ram_en    = (state == WRITE);
    assign ram_we    = (state == WRITE);
    assign ram_addr  = addr_q;
    assign ram_din   = word_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_bram_loader.sv
// Scoreboard bench for bram_loader: commands push expected BRAM writes, a monitor pops
// and compares each observed write, and a shadow memory is compared at the end.
module tb_bram_loader;

    localparam int AW    = 10;
    localparam int DW    = 96;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          busy;
    logic          done;

    bram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] pend[$];
    logic [31:0] beat_fifo[$];
    wr_t         exp_q[$];
    logic [DW-1:0] ref_mem[DEPTH];
    logic [DW-1:0] tb_mem[DEPTH];
    bit rand_valid = 1'b0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_target = 0;
    int last_accept = 0;
    int last_len = 0;

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chki({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chki({tag, "_s_ready"}, int'(s_ready), 0);
        chki({tag, "_ram_en"}, int'(ram_en), 0);
        chki({tag, "_ram_we"}, int'(ram_we), 0);
        chki({tag, "_ram_addr"}, int'(ram_addr), 0);
        chkw({tag, "_ram_din"}, ram_din, '0);
        chki({tag, "_busy"}, int'(busy), 0);
        chki({tag, "_done"}, int'(done), 0);
    endtask

    // Beat source: presents the head beat; a beat is consumed when valid meets ready.
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && beat_fifo.size() > 0) begin
                s_data  = beat_fifo[0];
                s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                if (s_valid && s_ready) void'(beat_fifo.pop_front());
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    // Monitor: compares every BRAM write against the scoreboard and tracks done pulses.
    initial begin
        logic prev_done;
        wr_t  e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_en || ram_we) chki("en_matches_we", int'(ram_en), int'(ram_we));
            if (ram_we === 1'b1) begin
                wr_cnt++;
                tb_mem[ram_addr] = ram_din;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h", ram_addr, ram_din);
                end else begin
                    e = exp_q.pop_front();
                    chki("wr_addr", int'(ram_addr), int'(e.addr));
                    chkw("wr_data", ram_din, e.data);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                chki("done_single_cycle", int'(prev_done), 0);
                chki("done_busy", int'(busy), 1);
                chki("done_cmd_ready", int'(cmd_ready), 0);
            end
            prev_done = done;
        end
    end

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) pend.push_back($urandom);
    endtask

    // Holds cmd_valid until accepted; the reference model then yields the expected writes.
    task automatic start_cmd(input logic [AW-1:0] base, input int len, input int exp_words);
        int waitc;
        wr_t e;
        logic [31:0] b0, b1, b2;
        waitc     = 0;
        cmd_base  = base;
        cmd_len   = len[AW:0];
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waitc < 20000) begin
            @(negedge clk);
            waitc++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout actual=not_ready expected=ready");
            cmd_valid = 1'b0;
            return;
        end
        chki("prior_cmds_done", done_cnt, done_target);
        done_target++;
        last_accept = cyc + 1;
        last_len    = len;
        for (int w = 0; w < len; w++) begin
            b0 = pend.pop_front();
            b1 = pend.pop_front();
            b2 = pend.pop_front();
            beat_fifo.push_back(b0);
            beat_fifo.push_back(b1);
            beat_fifo.push_back(b2);
            if (w < exp_words) begin
                e.addr = AW'((int'(base) + w) % DEPTH);
                e.data = {b2, b1, b0};
                exp_q.push_back(e);
                ref_mem[e.addr] = e.data;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit check_lat);
        int w;
        w = 0;
        while (done_cnt < done_target && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (done_cnt < done_target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d expected=%0d", done_cnt, done_target);
        end else if (check_lat) begin
            chki("done_latency", done_cyc - last_accept + 1, 4 * last_len + 1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int bad;
        int first_bad;
        logic [31:0] saved[$];
        int len;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            tb_mem[i]  = '0;
        end
        @(negedge clk);
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        // Two-word directed load
        pend = {32'h11111111, 32'h22222222, 32'h33333333,
                32'h44444444, 32'h55555555, 32'h66666666};
        start_cmd(10'd0, 2, 2);
        wait_done(1'b1);

        // Address wrap at the top of the BRAM
        fill_rand(9);
        start_cmd(10'd1022, 3, 3);
        wait_done(1'b1);

        // Zero-length command
        @(negedge clk);
        w0 = wr_cnt;
        start_cmd(AW'($urandom_range(0, DEPTH - 1)), 0, 0);
        chki("len0_done", int'(done), 1);
        chki("len0_cmd_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        chki("len0_cmd_ready_back", int'(cmd_ready), 1);
        chki("len0_done_low", int'(done), 0);
        wait_done(1'b1);
        chki("len0_no_write", wr_cnt - w0, 0);

        // Same four words with continuous and with random s_valid
        fill_rand(12);
        saved = pend;
        start_cmd(10'd100, 4, 4);
        wait_done(1'b1);
        w0 = wr_cnt;
        rand_valid = 1'b1;
        pend = saved;
        start_cmd(10'd100, 4, 4);
        wait_done(1'b0);
        rand_valid = 1'b0;
        chki("rand_valid_write_count", wr_cnt - w0, 4);

        // Reset after beat 1 of the second word
        fill_rand(9);
        w0 = wr_cnt;
        d0 = done_cnt;
        start_cmd(10'd500, 3, 1);
        while (cyc < last_accept + 6) @(negedge clk);
        rst = 1'b1;
        #1;
        beat_fifo.delete();
        s_valid = 1'b0;
        chk_reset_vals("midcmd_rst");
        chki("midcmd_rst_writes", wr_cnt - w0, 1);
        chki("midcmd_rst_exp_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chki("midcmd_rst_no_done", done_cnt - d0, 0);
        done_target = done_cnt;
        fill_rand(3);
        start_cmd(10'd7, 1, 1);
        wait_done(1'b1);

        // cmd_valid held high while a command is in progress
        @(negedge clk);
        fill_rand(15);
        fill_rand(9);
        start_cmd(10'd200, 5, 5);
        start_cmd(10'd300, 3, 3);
        wait_done(1'b1);

        // Full-depth load from a random base
        @(negedge clk);
        fill_rand(3 * DEPTH);
        w0 = wr_cnt;
        start_cmd(AW'($urandom_range(0, DEPTH - 1)), DEPTH, DEPTH);
        wait_done(1'b1);
        chki("full_depth_writes", wr_cnt - w0, DEPTH);

        // Random commands
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            len = $urandom_range(0, 24);
            rand_valid = 1'($urandom_range(0, 1));
            fill_rand(3 * len);
            start_cmd(AW'($urandom_range(0, DEPTH - 1)), len, len);
            wait_done(!rand_valid);
        end
        rand_valid = 1'b0;

        repeat (4) @(negedge clk);
        chki("scoreboard_drained", exp_q.size(), 0);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (tb_mem[i] !== ref_mem[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bram_contents mismatched_words=%0d first_addr=%0d expected_mismatches=0",
                     bad, first_bad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
